// File: rtl/arb_mux_reg.sv
// N-to-1 registered mux with per-channel valid/ready handshake. The select comes from a
// fixed-priority or round-robin arbiter, or from an external override index.
module arb_mux_reg #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic                    force_en,
  input  logic [SEL_W-1:0]        force_sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] rr_q, rr_d;

  logic             can_load;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  int               rr_idx;

  assign can_load = (state_q == StEmpty) || out_ready;

  // Arbitration. Loops run from the far end so the last hit (highest priority) wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_idx      = 0;
    if (!rst && can_load) begin
      if (force_en) begin
        // Out-of-range force_sel simply matches no channel.
        for (int i = 0; i < int'(NUM_IN); i++) begin
          if ((force_sel == SEL_W'(i)) && in_valid[i]) begin
            grant_valid = 1'b1;
            grant_idx   = SEL_W'(i);
          end
        end
      end else if (!mode) begin
        for (int i = int'(NUM_IN) - 1; i >= 0; i--) begin
          if (in_valid[i]) begin
            grant_valid = 1'b1;
            grant_idx   = SEL_W'(i);
          end
        end
      end else begin
        for (int off = int'(NUM_IN) - 1; off >= 0; off--) begin
          rr_idx = (int'(rr_q) + off) % int'(NUM_IN);
          for (int i = 0; i < int'(NUM_IN); i++) begin
            if ((i == rr_idx) && in_valid[i]) begin
              grant_valid = 1'b1;
              grant_idx   = SEL_W'(i);
            end
          end
        end
      end
    end
  end

  // One-hot ready and data select for the granted channel.
  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (grant_valid && (grant_idx == SEL_W'(i))) begin
        in_ready[i] = 1'b1;
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output stage state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Output stage next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (grant_valid) state_d = StFull;
      end
      StFull: begin
        if (out_ready && !grant_valid) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase
  end

  // Output stage outputs.
  always_comb begin
    out_valid = (state_q == StFull);
    out_data  = data_q;
    out_sel   = sel_q;
  end

  // Datapath and round-robin pointer next state.
  always_comb begin
    data_d = data_q;
    sel_d  = sel_q;
    rr_d   = rr_q;
    if (grant_valid) begin
      data_d = grant_data;
      sel_d  = grant_idx;
      if (!force_en && mode) begin
        rr_d = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      sel_q  <= '0;
      rr_q   <= '0;
    end else begin
      data_q <= data_d;
      sel_q  <= sel_d;
      rr_q   <= rr_d;
    end
  end

endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed bench for arb_mux_reg: a 4-channel instance for the main behaviour and a
// 3-channel instance for the out-of-range override boundary.
module tb_arb_mux_reg;

  logic         clk;
  logic         rst;
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic         mode;
  logic         force_en;
  logic [1:0]   force_sel;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_valid;
  logic         out_ready;

  logic [23:0]  in_data3;
  logic [2:0]   in_valid3;
  logic [2:0]   in_ready3;
  logic [1:0]   force_sel3;
  logic [7:0]   out_data3;
  logic [1:0]   out_sel3;
  logic         out_valid3;

  int n_cmp;
  int n_err;

  arb_mux_reg #(.WIDTH(32), .NUM_IN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .force_en  (force_en),
    .force_sel (force_sel),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  arb_mux_reg #(.WIDTH(8), .NUM_IN(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .mode      (1'b0),
    .force_en  (1'b1),
    .force_sel (force_sel3),
    .out_data  (out_data3),
    .out_sel   (out_sel3),
    .out_valid (out_valid3),
    .out_ready (1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] val);
    in_data[ch*32 +: 32] = val;
  endtask

  logic [1:0] rr_exp [6];
  logic [1:0] rr9_exp [4];

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rr_exp     = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rr9_exp    = '{2'd0, 2'd3, 2'd0, 2'd3};
    rst        = 1'b1;
    in_valid   = 4'b1111;
    in_data    = '0;
    for (int i = 0; i < 4; i++) set_ch(i, 32'h1000_0000 + i);
    mode       = 1'b0;
    force_en   = 1'b0;
    force_sel  = 2'd0;
    out_ready  = 1'b1;
    in_data3   = 24'h33_22_11;
    in_valid3  = 3'b111;
    force_sel3 = 2'd3;

    // Reset with every channel requesting.
    #1;
    chk("rst_in_ready_comb", 32'(in_ready), 32'h0);
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_sel", 32'(out_sel), 32'h0);

    // Fixed priority: channel 1 beats channel 3 every cycle.
    rst      = 1'b0;
    in_valid = 4'b1010;
    #1;
    chk("fp_in_ready0", 32'(in_ready), 32'h2);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fp_out_valid", 32'(out_valid), 32'h1);
      chk("fp_out_sel", 32'(out_sel), 32'h1);
      chk("fp_out_data", out_data, 32'h1000_0001 + 32'(k) * 32'h100);
      set_ch(1, 32'h1000_0101 + 32'(k) * 32'h100);
      #1;
      chk("fp_in_ready", 32'(in_ready), 32'h2);
    end

    // Round-robin over all four channels.
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    mode     = 1'b1;
    in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_in_ready", 32'(in_ready), 32'h1 << rr_exp[k]);
      tick();
      chk("rr_out_sel", 32'(out_sel), 32'(rr_exp[k]));
      chk("rr_out_valid", 32'(out_valid), 32'h1);
    end

    // Round-robin with only the two end channels requesting.
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr9_out_sel", 32'(out_sel), 32'(rr9_exp[k]));
      chk("rr9_out_data", out_data, 32'h1000_0000 + 32'(rr9_exp[k]));
    end

    // Backpressure holds the output word while the input keeps changing.
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    mode     = 1'b0;
    in_valid = 4'b0001;
    set_ch(0, 32'hDEAD_BEEF);
    tick();
    chk("bp_loaded", out_data, 32'hDEAD_BEEF);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_ch(0, 32'h5555_0000 + 32'(k));
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      tick();
      chk("bp_hold_data", out_data, 32'hDEAD_BEEF);
      chk("bp_hold_valid", 32'(out_valid), 32'h1);
    end
    set_ch(0, 32'hCAFE_F00D);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h1);
    tick();
    chk("bp_release_data", out_data, 32'hCAFE_F00D);

    // Override onto channel 2, then channel 2 drops.
    force_en  = 1'b1;
    force_sel = 2'd2;
    in_valid  = 4'b0111;
    #1;
    chk("ovr_in_ready", 32'(in_ready), 32'h4);
    tick();
    chk("ovr_out_sel", 32'(out_sel), 32'h2);
    chk("ovr_out_data", out_data, 32'h1000_0002);
    in_valid = 4'b0011;
    #1;
    chk("ovr_none_ready", 32'(in_ready), 32'h0);
    tick();
    chk("ovr_drain_valid", 32'(out_valid), 32'h0);
    force_en = 1'b0;

    // Three-channel build: index 3 is out of range and never grants.
    chk("n3_ready_oor", 32'(in_ready3), 32'h0);
    chk("n3_valid_oor", 32'(out_valid3), 32'h0);
    force_sel3 = 2'd2;
    #1;
    chk("n3_ready_2", 32'(in_ready3), 32'h4);
    tick();
    chk("n3_sel_2", 32'(out_sel3), 32'h2);
    chk("n3_data_2", 32'(out_data3), 32'h33);

    // Reset while holding a word with the round-robin pointer at 3.
    mode      = 1'b1;
    in_valid  = 4'b0100;
    tick();
    chk("mid_pre_sel", 32'(out_sel), 32'h2);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    rst       = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'h0);
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mid_first_ready", 32'(in_ready), 32'h1);
    tick();
    chk("mid_first_sel", 32'(out_sel), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
